// File: rtl/draw_player.sv
// Two-stage overlay that paints the player rectangle onto the incoming VGA stream.
// Optional one-pixel white outline is enabled by defining DRAW_PLAYER_BORDER_EN.
module draw_player #(
    parameter logic [10:0] XPOS      = 11'd100,
    parameter logic [10:0] WIDTH     = 11'd40,
    parameter logic [10:0] HEIGHT    = 11'd30,
    parameter logic [11:0] COLOR     = 12'hF_8_0,
    parameter logic [11:0] END_COLOR = 12'hF_0_0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [10:0] vcount_in,
    input  logic [10:0] hcount_in,
    input  logic        vsync_in,
    input  logic        vblnk_in,
    input  logic        hsync_in,
    input  logic        hblnk_in,
    input  logic [11:0] rgb_in,
    input  logic [11:0] ypos,
    input  logic        endgame,
    output logic [10:0] vcount_out,
    output logic [10:0] hcount_out,
    output logic        vsync_out,
    output logic        vblnk_out,
    output logic        hsync_out,
    output logic        hblnk_out,
    output logic [11:0] rgb_out
);

    localparam logic [11:0] VER_PIXELS = 12'd600;
    localparam logic [11:0] Y_MAX      = VER_PIXELS - {1'b0, HEIGHT};
    localparam logic [11:0] X_LO       = {1'b0, XPOS};
    localparam logic [11:0] X_HI       = {1'b0, XPOS} + {1'b0, WIDTH};

    function automatic logic [11:0] f_clamp_y(input logic [11:0] y);
        return (y > Y_MAX) ? Y_MAX : y;
    endfunction

    function automatic logic [11:0] f_rgb(input logic blank, input logic hit,
                                          input logic ended, input logic border,
                                          input logic [11:0] bg);
        if (blank)
            return 12'h000;
        else if (hit && border)
            return 12'hFFF;
        else if (hit)
            return ended ? END_COLOR : COLOR;
        else
            return bg;
    endfunction

    logic        r_vblnk_prev;
    logic [11:0] r_y_frame;
    logic        r_end_q;

    logic [11:0] w_h;
    logic [11:0] w_v;
    logic [11:0] w_y_bot;
    logic        w_vblnk_rise;
    logic        w_hit;
    logic        w_edge;
    logic        w_border_p1;

    assign w_h          = {1'b0, hcount_in};
    assign w_v          = {1'b0, vcount_in};
    assign w_y_bot      = r_y_frame + {1'b0, HEIGHT};
    assign w_vblnk_rise = vblnk_in & ~r_vblnk_prev;
    assign w_hit        = (w_h >= X_LO) && (w_h < X_HI) &&
                          (w_v >= r_y_frame) && (w_v < w_y_bot);

    // Frame-rate state: position only moves at the vblank rise, game-over is sticky
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vblnk_prev <= 1'b0;
            r_y_frame    <= 12'd0;
            r_end_q      <= 1'b0;
        end else begin
            r_vblnk_prev <= vblnk_in;
            if (w_vblnk_rise)
                r_y_frame <= f_clamp_y(ypos);
            if (endgame)
                r_end_q <= 1'b1;
        end
    end

    logic [10:0] r_vcount_p1, r_hcount_p1;
    logic        r_vsync_p1, r_vblnk_p1, r_hsync_p1, r_hblnk_p1;
    logic [11:0] r_rgb_p1;
    logic        r_hit_p1;
    logic        r_end_p1;

`ifdef DRAW_PLAYER_BORDER_EN
    logic r_border_p1;

    assign w_edge = (w_h == X_LO) || (w_h == X_HI - 12'd1) ||
                    (w_v == r_y_frame) || (w_v == w_y_bot - 12'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_border_p1 <= 1'b0;
        else
            r_border_p1 <= w_edge;
    end

    assign w_border_p1 = r_border_p1;
`else
    assign w_edge      = 1'b0;
    assign w_border_p1 = w_edge;
`endif

    // Stage 1: hit test against the frame-latched rectangle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vcount_p1 <= 11'd0;
            r_hcount_p1 <= 11'd0;
            r_vsync_p1  <= 1'b0;
            r_vblnk_p1  <= 1'b0;
            r_hsync_p1  <= 1'b0;
            r_hblnk_p1  <= 1'b0;
            r_rgb_p1    <= 12'd0;
            r_hit_p1    <= 1'b0;
            r_end_p1    <= 1'b0;
        end else begin
            r_vcount_p1 <= vcount_in;
            r_hcount_p1 <= hcount_in;
            r_vsync_p1  <= vsync_in;
            r_vblnk_p1  <= vblnk_in;
            r_hsync_p1  <= hsync_in;
            r_hblnk_p1  <= hblnk_in;
            r_rgb_p1    <= rgb_in;
            r_hit_p1    <= w_hit;
            r_end_p1    <= r_end_q;
        end
    end

    logic [10:0] r_vcount_p2, r_hcount_p2;
    logic        r_vsync_p2, r_vblnk_p2, r_hsync_p2, r_hblnk_p2;
    logic [11:0] r_rgb_p2;

    // Stage 2: colour select with blanking override
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vcount_p2 <= 11'd0;
            r_hcount_p2 <= 11'd0;
            r_vsync_p2  <= 1'b0;
            r_vblnk_p2  <= 1'b0;
            r_hsync_p2  <= 1'b0;
            r_hblnk_p2  <= 1'b0;
            r_rgb_p2    <= 12'd0;
        end else begin
            r_vcount_p2 <= r_vcount_p1;
            r_hcount_p2 <= r_hcount_p1;
            r_vsync_p2  <= r_vsync_p1;
            r_vblnk_p2  <= r_vblnk_p1;
            r_hsync_p2  <= r_hsync_p1;
            r_hblnk_p2  <= r_hblnk_p1;
            r_rgb_p2    <= f_rgb(r_hblnk_p1 | r_vblnk_p1, r_hit_p1, r_end_p1,
                                 w_border_p1, r_rgb_p1);
        end
    end

    assign vcount_out = r_vcount_p2;
    assign hcount_out = r_hcount_p2;
    assign vsync_out  = r_vsync_p2;
    assign vblnk_out  = r_vblnk_p2;
    assign hsync_out  = r_hsync_p2;
    assign hblnk_out  = r_hblnk_p2;
    assign rgb_out    = r_rgb_p2;

endmodule

// File: doc/draw_player.md
DRAW_PLAYER -- requirements
Module: draw_player

Interface
Parameters: name, default, meaning.
REQ-001 The block SHALL have parameter XPOS, default 11'd100: left edge column of the player rectangle.
REQ-002 The block SHALL have parameter WIDTH, default 11'd40: rectangle width in pixels.
REQ-003 The block SHALL have parameter HEIGHT, default 11'd30: rectangle height in pixels.
REQ-004 The block SHALL have parameter COLOR, default 12'hF_8_0: rectangle fill colour while playing.
REQ-005 The block SHALL have parameter END_COLOR, default 12'hF_0_0: rectangle fill colour after endgame.

Ports: name, direction, width, meaning.
REQ-006 The block SHALL have port clk, input, 1: single pixel clock; all state on rising edge.
REQ-007 The block SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-008 The block SHALL have input ports vcount_in and hcount_in (11 bits each) and vsync_in, vblnk_in, hsync_in and hblnk_in (1 bit each): incoming VGA timing.
REQ-009 The block SHALL have port rgb_in, input, 12: incoming background pixel.
REQ-010 The block SHALL have port ypos, input, 12: player top row, driven by the player-position controller.
REQ-011 The block SHALL have port endgame, input, 1: game-over flag from the player-position controller.
REQ-012 The block SHALL have output ports vcount_out, hcount_out, vsync_out, vblnk_out, hsync_out, hblnk_out and rgb_out: timing and rgb, widths equal to the matching inputs.

Function
REQ-013 All outputs SHALL be registered, with a fixed 2-cycle latency from input to output. Timing signals SHALL be delayed through two stages unchanged.
REQ-014 ypos SHALL be sampled into a frame register y_frame only on the cycle where vblnk_in rises (previous vblnk_in 0, current 1), so that position changes never tear mid-frame.
REQ-015 y_frame SHALL be clamped to VER_PIXELS-HEIGHT (vga_pkg) when sampled ypos exceeds that value.
REQ-016 Bit 11 of ypos SHALL be treated as part of the magnitude, not as a sign; clamp comparison SHALL be unsigned 12-bit.
REQ-017 endgame SHALL be latched into a sticky flag end_q on any cycle it is 1. end_q SHALL clear only on reset.
REQ-018 Stage 1 SHALL compute hit = (hcount_in >= XPOS) && (hcount_in < XPOS+WIDTH) && (vcount_in >= y_frame) && (vcount_in < y_frame+HEIGHT), with 12-bit unsigned arithmetic (no wrap).
REQ-019 Stage 2 rgb_out SHALL be 12'h000 if the delayed hblnk or vblnk is 1.
REQ-020 Otherwise stage 2 rgb_out SHALL be END_COLOR if hit and end_q, else COLOR if hit, else the delayed rgb_in.
REQ-021 If the vblnk rising edge and a change of endgame occur in the same cycle, both SHALL take effect on that clock edge.
REQ-022 end_q SHALL colour the rectangle starting with the first pixel whose stage-1 evaluation follows the latch, even mid-frame.

Reset
REQ-023 On rst_n low, all pipeline registers, y_frame and end_q SHALL clear to 0 asynchronously. All outputs SHALL read 0 until 2 clocks after rst_n rises.
REQ-024 Reset asserted mid-frame SHALL discard in-flight pixels. The first frame after reset SHALL draw at y_frame=0 until the next vblnk rise.

Configuration
REQ-025 The macro DRAW_PLAYER_BORDER_EN SHALL control the border. When defined, rectangle pixels on the outermost row or column SHALL output 12'hFFF; interior pixels SHALL follow REQ-020 unchanged.
REQ-026 When DRAW_PLAYER_BORDER_EN is undefined, the whole rectangle SHALL be flat-filled per REQ-020, with no border logic synthesised.

Verification
REQ-027 Reset with ypos=200, then run one frame -> rectangle at rows 0..29, cols 100..139, colour 12'hF80. After the vblnk rise, the next frame -> rows 200..229.
REQ-028 ypos changes 200->300 mid-frame (hcount=50, vcount=210) -> the current frame stays at rows 200..229; the next frame is at 300..329.
REQ-029 ypos=12'd4000 at the vblnk rise -> y_frame=VER_PIXELS-30. The rectangle's bottom row is VER_PIXELS-1 with no wrap to row 0.
REQ-030 endgame pulses for 1 cycle at vcount=215 -> rectangle rows 215..229 are 12'hF00 (rows 200..214 stay 12'hF80). All later frames are 12'hF00.
REQ-031 hblnk_in=1 at a hit position, and background rgb_in=12'h0A0 outside the rectangle -> rgb_out=0 during blanking and 12'h0A0 elsewhere. All outputs lag the inputs by exactly 2 clocks.
REQ-032 With DRAW_PLAYER_BORDER_EN defined, pixel (100,200) -> 12'hFFF and pixel (101,201) -> 12'hF80. Undefined -> both pixels are 12'hF80.
